// File: rtl/mux_nx1_stream.sv
// N-input registered stream multiplexer with valid/ready handshake.
// An internal fixed-priority or round-robin arbiter picks the source; an optional lock holds the last grant.
module mux_nx1_stream #(
  parameter int BITWIDTH = 32,
  parameter int NCH      = 4,
  parameter int MODE     = 0,
  localparam int CW      = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*BITWIDTH-1:0] in_data,
  output logic [NCH-1:0]          in_ready,
  input  logic                    lock,
  output logic                    out_valid,
  output logic [BITWIDTH-1:0]     out_data,
  output logic [CW-1:0]           out_sel,
  input  logic                    out_ready
);

  localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

  logic                load_en_s;
  logic                found_s;
  logic [CW-1:0]       gidx_s;
  logic [CW:0]         sum_s;
  logic [CW:0]         cand_s;
  logic [BITWIDTH-1:0] gdata_s;
  logic [NCH-1:0]      in_ready_s;

  logic                out_valid_r;
  logic [BITWIDTH-1:0] out_data_r;
  logic [CW-1:0]       out_sel_r;
  logic [CW-1:0]       ptr_r;

  assign load_en_s = !out_valid_r | out_ready;

  // Arbiter: grant depends only on in_valid, ptr and lock; loops run farthest-first so the nearest candidate wins.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    sum_s   = '0;
    cand_s  = '0;
    if (lock && in_valid[ptr_r]) begin
      found_s = 1'b1;
      gidx_s  = ptr_r;
    end else if (MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        found_s = found_s | in_valid[i];
        gidx_s  = in_valid[i] ? CW'(i) : gidx_s;
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        sum_s   = {1'b0, ptr_r} + (CW+1)'(k);
        cand_s  = (sum_s >= NCH_W) ? (sum_s - NCH_W) : sum_s;
        found_s = found_s | in_valid[cand_s[CW-1:0]];
        gidx_s  = in_valid[cand_s[CW-1:0]] ? cand_s[CW-1:0] : gidx_s;
      end
    end
  end

  // Data select and per-channel ready; ready is held low while reset is asserted.
  always_comb begin
    gdata_s    = '0;
    in_ready_s = '0;
    for (int i = 0; i < NCH; i++) begin
      gdata_s       = (gidx_s == CW'(i)) ? in_data[i*BITWIDTH +: BITWIDTH] : gdata_s;
      in_ready_s[i] = !reset & load_en_s & found_s & (gidx_s == CW'(i));
    end
  end

  // Output register and last-grant pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= CW'(NCH - 1);
    end else if (load_en_s) begin
      if (found_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= gdata_s;
        out_sel_r   <= gidx_s;
        ptr_r       <= gidx_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream: one fixed-priority and one round-robin instance, NCH=4, 32-bit data.
module tb_mux_nx1_stream;

  logic         clk;
  logic         reset;

  logic [3:0]   v0, rdy0, v1, rdy1;
  logic [127:0] d0, d1;
  logic         lock0, lock1, ov0, ov1, ordy0, ordy1;
  logic [31:0]  od0, od1;
  logic [1:0]   os0, os1;

  int n_checks;
  int n_fail;

  mux_nx1_stream #(.BITWIDTH(32), .NCH(4), .MODE(0)) u_fp (
    .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0), .in_ready(rdy0), .lock(lock0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0)
  );

  mux_nx1_stream #(.BITWIDTH(32), .NCH(4), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1), .in_ready(rdy1), .lock(lock1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    v0 = 4'h0; d0 = '0; lock0 = 1'b0; ordy0 = 1'b0;
    v1 = 4'hF; d1 = '0; lock1 = 1'b0; ordy1 = 1'b1;

    // Reset state; ready must stay low even with valid inputs.
    #1;
    check("rst_rdy_rr", {28'd0, rdy1}, 32'h0);
    check("rst_ov_fp", {31'd0, ov0}, 32'h0);
    check("rst_od_fp", od0, 32'h0);
    check("rst_os_rr", {30'd0, os1}, 32'h0);
    tick();
    check("rst_ov_rr", {31'd0, ov1}, 32'h0);
    v1 = 4'h0;
    #2 reset = 1'b0;
    tick();

    // Single source, fixed priority.
    v0 = 4'b0100; ordy0 = 1'b1;
    d0 = {32'h0BAD_0003, 32'hA5A5_0002, 32'h0BAD_0001, 32'h0BAD_0000};
    #1 check("single_rdy", {28'd0, rdy0}, 32'h4);
    tick();
    check("single_ov", {31'd0, ov0}, 32'h1);
    check("single_od", od0, 32'hA5A5_0002);
    check("single_os", {30'd0, os0}, 32'h2);

    // All valid, fixed priority: channel 0 always.
    v0 = 4'hF;
    d0 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    repeat (4) begin
      #1 check("fp_rdy", {28'd0, rdy0}, 32'h1);
      tick();
      check("fp_os", {30'd0, os0}, 32'h0);
      check("fp_od", od0, 32'h1000_0000);
      check("fp_ov", {31'd0, ov0}, 32'h1);
    end

    // No valid input: output empties, data and sel hold.
    v0 = 4'h0;
    #1 check("idle_rdy", {28'd0, rdy0}, 32'h0);
    tick();
    check("idle_ov", {31'd0, ov0}, 32'h0);
    check("idle_od", od0, 32'h1000_0000);
    check("idle_os", {30'd0, os0}, 32'h0);

    // Round-robin fairness and wrap.
    v1 = 4'hF; ordy1 = 1'b1; lock1 = 1'b0;
    d1 = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_rdy", {28'd0, rdy1}, 32'h1 << (k % 4));
      tick();
      check("rr_os", {30'd0, os1}, 32'(k % 4));
      check("rr_od", od1, 32'h2000_0000 + 32'(k % 4));
      check("rr_ov", {31'd0, ov1}, 32'h1);
    end

    // Backpressure holds everything; release grants the channel after the held one (wraps to 0).
    ordy1 = 1'b0;
    repeat (3) begin
      #1 check("bp_rdy", {28'd0, rdy1}, 32'h0);
      tick();
      check("bp_os", {30'd0, os1}, 32'h3);
      check("bp_od", od1, 32'h2000_0003);
      check("bp_ov", {31'd0, ov1}, 32'h1);
    end
    ordy1 = 1'b1;
    #1 check("bp_rel_rdy", {28'd0, rdy1}, 32'h1);
    tick();
    check("bp_rel_os", {30'd0, os1}, 32'h0);

    // Lock on channel 1, then fall through when it goes idle.
    v1 = 4'b0110;
    #1 check("lk_pre_rdy", {28'd0, rdy1}, 32'h2);
    tick();
    check("lk_pre_os", {30'd0, os1}, 32'h1);
    lock1 = 1'b1;
    repeat (3) begin
      #1 check("lk_rdy", {28'd0, rdy1}, 32'h2);
      tick();
      check("lk_os", {30'd0, os1}, 32'h1);
      check("lk_od", od1, 32'h2000_0001);
    end
    v1 = 4'b0100;
    #1 check("lk_drop_rdy", {28'd0, rdy1}, 32'h4);
    tick();
    check("lk_drop_os", {30'd0, os1}, 32'h2);

    // Asynchronous reset between edges while output is full.
    v1 = 4'hF; lock1 = 1'b0; ordy1 = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_ov", {31'd0, ov1}, 32'h0);
    check("arst_od", od1, 32'h0);
    check("arst_os", {30'd0, os1}, 32'h0);
    check("arst_rdy", {28'd0, rdy1}, 32'h0);
    check("arst_od_fp", od0, 32'h0);
    tick();
    #2 reset = 1'b0;
    #1 check("post_rst_rdy", {28'd0, rdy1}, 32'h1);
    tick();
    check("post_rst_os", {30'd0, os1}, 32'h0);
    check("post_rst_od", od1, 32'h2000_0000);
    check("post_rst_ov", {31'd0, ov1}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
